// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input controller: register word addresses
// and data/bank widths used by the bus decode and the switch read path.
package gpio_pkg;

  localparam int DATA_W = 32;
  localparam int BANK_W = 8;

  localparam logic [3:0] ADDR_SW0   = 4'd0;
  localparam logic [3:0] ADDR_KEY   = 4'd8;
  localparam logic [3:0] ADDR_PEND  = 4'd9;
  localparam logic [3:0] ADDR_IRQEN = 4'd10;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input bit: 2-FF synchroniser followed (when GPIO_DEBOUNCE_EN is
// defined) by a STABLE_N-deep tick-sampled history and a stable-level FF.
// Without GPIO_DEBOUNCE_EN the level is simply the inverted synchronised pin.
// The pin is active-low; level is active-high.
module gpio_debounce_bit
`ifdef GPIO_DEBOUNCE_EN
  #(parameter int STABLE_N = 3)
`endif
(
  input  logic clk_in,
  input  logic sys_rstn,
`ifdef GPIO_DEBOUNCE_EN
  input  logic tick,
`endif
  input  logic pin,
  output logic level
);

  logic sync0_r;
  logic sync1_r;

  // Two-stage synchroniser, resets to the inactive (high) pin level
  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      sync0_r <= 1'b1;
      sync1_r <= 1'b1;
    end else begin
      sync0_r <= pin;
      sync1_r <= sync0_r;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [STABLE_N-1:0] hist_r;
  logic [STABLE_N-1:0] hist_nx_s;
  logic                all_same_s;
  logic                stable_r;

  // History after this tick's shift; acceptance looks at the new window
  always_comb begin
    hist_nx_s  = {hist_r[STABLE_N-2:0], sync1_r};
    all_same_s = (&hist_nx_s) | (~|hist_nx_s);
  end

  // Shift on tick and accept a new level once the whole window agrees
  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      hist_r   <= {STABLE_N{1'b1}};
      stable_r <= 1'b0;
    end else if (tick) begin
      hist_r <= hist_nx_s;
      if (all_same_s && (stable_r == sync1_r)) begin
        stable_r <= ~sync1_r;
      end
    end
  end

  assign level = stable_r;
`else
  assign level = ~sync1_r;
`endif

endmodule

// File: rtl/gpio_input_ctrl.sv
// Bus-mapped GPIO input block: NUM_BANKS 8-bit switch banks and KEY_W keys,
// each synchronised and (with GPIO_DEBOUNCE_EN defined) debounced on a shared
// sample tick. Key rising edges set sticky pending bits (write-1-to-clear);
// irq is the registered OR of pending bits enabled in irq_en.
// Optional feature macro: GPIO_DEBOUNCE_EN.
module gpio_input_ctrl
  import gpio_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int KEY_W     = 8,
  parameter int TICK_DIV  = 50000,
  parameter int STABLE_N  = 3
) (
  input  logic                        clk_in,
  input  logic                        sys_rstn,
  input  logic [NUM_BANKS*BANK_W-1:0] dip_switch,
  input  logic [KEY_W-1:0]            user_key,
  input  logic [3:0]                  addr,
  input  logic                        we,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata,
  output logic                        irq
);

  logic [NUM_BANKS*BANK_W-1:0] sw_level_s;
  logic [KEY_W-1:0]            key_level_s;
  logic [4*DATA_W-1:0]         sw_pad_s;
  logic [KEY_W-1:0]            key_prev_r;
  logic [KEY_W-1:0]            key_rise_s;
  logic [KEY_W-1:0]            pend_r;
  logic [KEY_W-1:0]            pend_nx_s;
  logic [KEY_W-1:0]            irq_en_r;
  logic [KEY_W-1:0]            irq_en_nx_s;
  logic                        irq_r;
  logic                        unused_wdata_s;

  assign unused_wdata_s = ^wdata;

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] tick_cnt_r;
  logic             tick_s;

  assign tick_s = (tick_cnt_r == CNT_W'(TICK_DIV - 1));

  // Shared sample-tick divider: 0..TICK_DIV-1, wraps on tick
  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      tick_cnt_r <= {CNT_W{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {CNT_W{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + CNT_W'(1);
    end
  end
`else
  localparam int unused_cfg = TICK_DIV + STABLE_N;
`endif

  for (genvar i = 0; i < NUM_BANKS*BANK_W; i++) begin : g_sw
    gpio_debounce_bit
`ifdef GPIO_DEBOUNCE_EN
      #(.STABLE_N(STABLE_N))
`endif
    u_bit (
      .clk_in   (clk_in),
      .sys_rstn (sys_rstn),
`ifdef GPIO_DEBOUNCE_EN
      .tick     (tick_s),
`endif
      .pin      (dip_switch[i]),
      .level    (sw_level_s[i])
    );
  end

  for (genvar k = 0; k < KEY_W; k++) begin : g_key
    gpio_debounce_bit
`ifdef GPIO_DEBOUNCE_EN
      #(.STABLE_N(STABLE_N))
`endif
    u_bit (
      .clk_in   (clk_in),
      .sys_rstn (sys_rstn),
`ifdef GPIO_DEBOUNCE_EN
      .tick     (tick_s),
`endif
      .pin      (user_key[k]),
      .level    (key_level_s[k])
    );
  end

  assign key_rise_s = key_level_s & ~key_prev_r;
  assign sw_pad_s   = (4*DATA_W)'(sw_level_s);

  // Next-state for pend (a rise beats a same-cycle clear) and irq_en
  always_comb begin
    pend_nx_s   = pend_r | key_rise_s;
    irq_en_nx_s = irq_en_r;
    if (we && (addr == ADDR_PEND)) begin
      pend_nx_s = (pend_r & ~wdata[KEY_W-1:0]) | key_rise_s;
    end else if (we && (addr == ADDR_IRQEN)) begin
      irq_en_nx_s = wdata[KEY_W-1:0];
    end else begin
      pend_nx_s   = pend_r | key_rise_s;
      irq_en_nx_s = irq_en_r;
    end
  end

  // Edge history, pending/enable registers and the registered interrupt
  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      key_prev_r <= {KEY_W{1'b0}};
      pend_r     <= {KEY_W{1'b0}};
      irq_en_r   <= {KEY_W{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      key_prev_r <= key_level_s;
      pend_r     <= pend_nx_s;
      irq_en_r   <= irq_en_nx_s;
      irq_r      <= |(pend_nx_s & irq_en_nx_s);
    end
  end

  assign irq = irq_r;

  // Read mux: switch words 0-3, KEY, PEND, IRQ_EN; everything else reads 0
  always_comb begin
    rdata = {DATA_W{1'b0}};
    case (addr)
      ADDR_KEY:   rdata = DATA_W'(key_level_s);
      ADDR_PEND:  rdata = DATA_W'(pend_r);
      ADDR_IRQEN: rdata = DATA_W'(irq_en_r);
      default: begin
        if (addr[3:2] == ADDR_SW0[3:2]) begin
          rdata = sw_pad_s[{addr[1:0], 5'd0} +: DATA_W];
        end else begin
          rdata = {DATA_W{1'b0}};
        end
      end
    endcase
  end

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Directed bench for gpio_input_ctrl (TICK_DIV=4, STABLE_N=3). Latency
// expectations follow GPIO_DEBOUNCE_EN: 2+3*4 cycles worst case when defined,
// exactly 2 cycles when not.
module tb_gpio_input_ctrl;

`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT_MAX   = 14;
  localparam int REACQ_MIN = 12;
  localparam int REACQ_MAX = 15;
`else
  localparam int LAT_MAX   = 2;
  localparam int REACQ_MIN = 3;
  localparam int REACQ_MAX = 3;
`endif

  logic        clk_in = 1'b0;
  logic        sys_rstn;
  logic [63:0] dip_switch;
  logic [7:0]  user_key;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  gpio_input_ctrl #(
    .NUM_BANKS (8),
    .KEY_W     (8),
    .TICK_DIV  (4),
    .STABLE_N  (3)
  ) dut (
    .clk_in     (clk_in),
    .sys_rstn   (sys_rstn),
    .dip_switch (dip_switch),
    .user_key   (user_key),
    .addr       (addr),
    .we         (we),
    .wdata      (wdata),
    .rdata      (rdata),
    .irq        (irq)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    addr  = a;
    we    = 1'b1;
    wdata = d;
    step();
    we    = 1'b0;
    wdata = 32'd0;
  endtask

  // Poll a register until it equals exp or budget cycles elapse
  task automatic poll(input logic [3:0] a, input logic [31:0] exp, input int budget,
                      output int n, output logic [31:0] got);
    addr = a;
    #1;
    n   = 0;
    got = rdata;
    while ((got !== exp) && (n < budget)) begin
      step();
      #1;
      n   = n + 1;
      got = rdata;
    end
  endtask

  task automatic test_reset();
    int          n;
    logic [31:0] got;
    sys_rstn   = 1'b0;
    we         = 1'b0;
    addr       = 4'd0;
    wdata      = 32'd0;
    user_key   = 8'hff;
    dip_switch = {8'hff, 8'hff, 8'hff, ~8'h44, 8'hff, 8'hff, 8'hff, ~8'hc3};
    step();
    step();
    #1;
    n_vec++;
    if (rdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_sw0: got %h expected %h", rdata, 32'd0);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    @(negedge clk_in);
    sys_rstn = 1'b1;
    poll(4'd0, 32'h0000_00c3, 20, n, got);
    n_vec++;
    if (got !== 32'h0000_00c3) begin
      n_err++;
      $display("FAIL sw0_value: got %h expected %h", got, 32'h0000_00c3);
    end
    n_vec++;
    if (n > LAT_MAX) begin
      n_err++;
      $display("FAIL sw0_latency: got %0d cycles expected <= %0d", n, LAT_MAX);
    end
    addr = 4'd1;
    #1;
    n_vec++;
    if (rdata !== 32'h0000_0044) begin
      n_err++;
      $display("FAIL sw1_value: got %h expected %h", rdata, 32'h0000_0044);
    end
    for (int a = 2; a < 16; a++) begin
      addr = 4'(a);
      #0.1;
      n_vec++;
      if (rdata !== 32'd0) begin
        n_err++;
        $display("FAIL other_addr_%0d: got %h expected %h", a, rdata, 32'd0);
      end
    end
  endtask

  task automatic test_switch_update();
    int          n;
    logic [31:0] got;
    dip_switch[7:0] = ~8'h12;
    poll(4'd0, 32'h0000_0012, 20, n, got);
    n_vec++;
    if (got !== 32'h0000_0012) begin
      n_err++;
      $display("FAIL sw0_update: got %h expected %h", got, 32'h0000_0012);
    end
    n_vec++;
    if (n > LAT_MAX) begin
      n_err++;
      $display("FAIL sw0_update_latency: got %0d cycles expected <= %0d", n, LAT_MAX);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL sw_no_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_key_irq();
    int          n;
    logic [31:0] got;
    bus_write(4'd10, 32'hffff_ffff);
    addr = 4'd10;
    #1;
    n_vec++;
    if (rdata !== 32'h0000_00ff) begin
      n_err++;
      $display("FAIL irq_en_width: got %h expected %h", rdata, 32'h0000_00ff);
    end
    @(negedge clk_in);
    bus_write(4'd10, 32'h0000_0001);
    addr = 4'd10;
    #1;
    n_vec++;
    if (rdata !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL irq_en_write: got %h expected %h", rdata, 32'h0000_0001);
    end
    @(negedge clk_in);
    user_key = ~8'd1;
    poll(4'd8, 32'h0000_0001, 20, n, got);
    n_vec++;
    if ((got !== 32'h0000_0001) || (n > LAT_MAX)) begin
      n_err++;
      $display("FAIL key_press: got %h after %0d cycles expected %h within %0d",
               got, n, 32'h0000_0001, LAT_MAX);
    end
    step();
    addr = 4'd9;
    #1;
    n_vec++;
    if (rdata !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL pend_set: got %h expected %h", rdata, 32'h0000_0001);
    end
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_set: got %b expected 1", irq);
    end
    @(negedge clk_in);
    bus_write(4'd9, 32'h0000_0001);
    addr = 4'd9;
    #1;
    n_vec++;
    if (rdata !== 32'd0) begin
      n_err++;
      $display("FAIL pend_clear: got %h expected %h", rdata, 32'd0);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear: got %b expected 0", irq);
    end
    @(negedge clk_in);
    bus_write(4'd8, 32'h0000_0000);
    bus_write(4'd0, 32'hffff_ffff);
    repeat (20) step();
    addr = 4'd9;
    #1;
    n_vec++;
    if (rdata !== 32'd0) begin
      n_err++;
      $display("FAIL pend_held_key: got %h expected %h", rdata, 32'd0);
    end
    addr = 4'd8;
    #1;
    n_vec++;
    if (rdata !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL key_ro_write: got %h expected %h", rdata, 32'h0000_0001);
    end
    addr = 4'd0;
    #1;
    n_vec++;
    if (rdata !== 32'h0000_0012) begin
      n_err++;
      $display("FAIL sw_ro_write: got %h expected %h", rdata, 32'h0000_0012);
    end
    @(negedge clk_in);
  endtask

  task automatic test_glitch();
    int          n;
    logic [31:0] got;
    logic [31:0] seen_key;
    logic [31:0] seen_pend;
    user_key = 8'hff;
    poll(4'd8, 32'd0, 20, n, got);
    n_vec++;
    if (got !== 32'd0) begin
      n_err++;
      $display("FAIL key_release: got %h expected %h", got, 32'd0);
    end
    @(negedge clk_in);
`ifdef GPIO_DEBOUNCE_EN
    seen_key  = 32'd0;
    seen_pend = 32'd0;
    user_key[0] = 1'b0;
    repeat (8) step();
    user_key[0] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      addr = 4'd8;
      #1;
      seen_key = seen_key | rdata;
      addr = 4'd9;
      #1;
      seen_pend = seen_pend | rdata;
      step();
    end
    n_vec++;
    if (seen_key !== 32'd0) begin
      n_err++;
      $display("FAIL glitch_key: got %h expected %h", seen_key, 32'd0);
    end
    n_vec++;
    if (seen_pend !== 32'd0) begin
      n_err++;
      $display("FAIL glitch_pend: got %h expected %h", seen_pend, 32'd0);
    end
`else
    user_key = ~8'd1;
    step();
    addr = 4'd8;
    #1;
    n_vec++;
    if (rdata !== 32'd0) begin
      n_err++;
      $display("FAIL key_lat_early: got %h expected %h", rdata, 32'd0);
    end
    step();
    #1;
    n_vec++;
    if (rdata !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL key_lat_exact: got %h expected %h", rdata, 32'h0000_0001);
    end
    step();
    addr = 4'd9;
    #1;
    n_vec++;
    if (rdata !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL key_lat_pend: got %h expected %h", rdata, 32'h0000_0001);
    end
    @(negedge clk_in);
    user_key = 8'hff;
    bus_write(4'd9, 32'h0000_0001);
    poll(4'd8, 32'd0, 20, n, got);
    addr = 4'd9;
    #1;
    n_vec++;
    if (rdata !== 32'd0) begin
      n_err++;
      $display("FAIL key_lat_pend_clr: got %h expected %h", rdata, 32'd0);
    end
    @(negedge clk_in);
`endif
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_clear_vs_rise();
    int          n;
    logic [31:0] got;
    user_key = ~8'd1;
    poll(4'd8, 32'h0000_0001, 20, n, got);
    n_vec++;
    if (got !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL race_key: got %h expected %h", got, 32'h0000_0001);
    end
    addr  = 4'd9;
    we    = 1'b1;
    wdata = 32'h0000_0001;
    step();
    we    = 1'b0;
    wdata = 32'd0;
    #1;
    n_vec++;
    if (rdata !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL race_pend: got %h expected %h", rdata, 32'h0000_0001);
    end
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL race_irq: got %b expected 1", irq);
    end
    @(negedge clk_in);
  endtask

  task automatic test_reset_midop();
    int          n;
    logic [31:0] got;
    sys_rstn = 1'b0;
    step();
    addr = 4'd9;
    #1;
    n_vec++;
    if (rdata !== 32'd0) begin
      n_err++;
      $display("FAIL rst_pend: got %h expected %h", rdata, 32'd0);
    end
    addr = 4'd10;
    #1;
    n_vec++;
    if (rdata !== 32'd0) begin
      n_err++;
      $display("FAIL rst_irq_en: got %h expected %h", rdata, 32'd0);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL rst_irq: got %b expected 0", irq);
    end
    addr = 4'd8;
    #1;
    n_vec++;
    if (rdata !== 32'd0) begin
      n_err++;
      $display("FAIL rst_key: got %h expected %h", rdata, 32'd0);
    end
    @(negedge clk_in);
    sys_rstn = 1'b1;
    poll(4'd9, 32'h0000_0001, 30, n, got);
    n_vec++;
    if (got !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL reacq_pend: got %h expected %h", got, 32'h0000_0001);
    end
    n_vec++;
    if ((n < REACQ_MIN) || (n > REACQ_MAX)) begin
      n_err++;
      $display("FAIL reacq_latency: got %0d cycles expected %0d..%0d", n, REACQ_MIN, REACQ_MAX);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reacq_irq: got %b expected 0", irq);
    end
  endtask

  initial begin
    test_reset();
    test_switch_update();
    test_key_irq();
    test_glitch();
    test_clear_vs_rise();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
